// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types, widths and saturation helper for the neuron layer sequencer.
package neuron_pkg;
   localparam int NEURON_W = 8;
   localparam int ACC_W    = 22;
   typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;
   function automatic logic signed [NEURON_W-1:0] sat8(input logic signed [ACC_W-1:0] v);
      return (v > 22'sd127) ? 8'sh7f : (v < -22'sd128) ? 8'sh80 : v[NEURON_W-1:0];
   endfunction
endpackage

// File: rtl/neuron_mac.sv
// neuron_mac: signed 8x8 multiply-accumulate into a 22-bit signed accumulator.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (wins over en)
//   en       : accumulate a*b this edge
//   a, b     : signed neuron value and weight
//   acc      : running signed sum
module neuron_mac
   import neuron_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       en,
   input  logic signed [NEURON_W-1:0] a,
   input  logic signed [NEURON_W-1:0] b,
   output logic signed [ACC_W-1:0]    acc
);
   logic signed [2*NEURON_W-1:0] prod;
   assign prod = a * b;
   always_ff @(posedge clk or posedge rst)
      if (rst) acc <= '0;
      else if (clr) acc <= '0;
      else if (en) acc <= acc + ACC_W'(prod);
endmodule

// File: rtl/neuron_layer_sequencer.sv
// neuron_layer_sequencer: computes N_OUT dense-layer outputs from N_IN RAM inputs and ROM weights.
//   clk, rst            : clock, async active-high reset
//   start, busy, done   : run request, run in progress, one-cycle completion pulse
//   ram_read_address/ram_oe/ram_read_data   : neuron RAM read side (combinational read)
//   ram_write_address/ram_write_data/ram_wre: neuron RAM write side
//   w_addr/w_data       : weight ROM (combinational read), weight j*N_IN+i
// Optional: define NEURON_RELU_EN to clamp negative results to 0 after saturation.
module neuron_layer_sequencer
   import neuron_pkg::*;
#(
   parameter int N_IN     = 4,
   parameter int N_OUT    = 2,
   parameter int IN_BASE  = 0,
   parameter int OUT_BASE = 20,
   parameter int FRAC     = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic [7:0]                 ram_read_address,
   output logic                       ram_oe,
   input  logic signed [NEURON_W-1:0] ram_read_data,
   output logic [7:0]                 ram_write_address,
   output logic signed [NEURON_W-1:0] ram_write_data,
   output logic                       ram_wre,
   output logic [7:0]                 w_addr,
   input  logic signed [NEURON_W-1:0] w_data
);
   // Regions are checked on the 256-entry circular address space.
   localparam int D_IO = (IN_BASE - OUT_BASE) & 255;
   localparam int D_OI = (OUT_BASE - IN_BASE) & 255;
   if (N_IN < 1 || N_IN > 64 || N_OUT < 1 || N_OUT > 64 || FRAC < 0 || FRAC > 8) begin : g_bad_range
      $error("neuron_layer_sequencer: parameter out of range");
   end
   if (D_IO < N_OUT || D_OI < N_IN) begin : g_overlap
      $error("neuron_layer_sequencer: input and output regions overlap");
   end

   state_t state, state_nxt;
   logic [6:0] i, j;
   logic [7:0] w_addr_q, w_addr_c;
   logic clr, en, last_i, last_j;
   logic signed [ACC_W-1:0] acc, acc_sh;
   logic signed [NEURON_W-1:0] sat, result;

   assign last_i   = i == 7'(N_IN - 1);
   assign last_j   = j == 7'(N_OUT - 1);
   assign w_addr_c = 8'(j) * 8'(N_IN) + 8'(i);
   assign acc_sh   = acc >>> FRAC;
   assign sat      = sat8(acc_sh);
`ifdef NEURON_RELU_EN
   assign result   = sat[NEURON_W-1] ? '0 : sat;
`else
   assign result   = sat;
`endif

   neuron_mac u_mac (
      .clk(clk), .rst(rst), .clr(clr), .en(en),
      .a(ram_read_data), .b(w_data), .acc(acc)
   );

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nxt;

   // w_addr_q remembers the last weight address so it holds outside MAC.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         i        <= '0;
         j        <= '0;
         w_addr_q <= '0;
      end else if (state == IDLE && start) begin
         i <= '0;
         j <= '0;
      end else if (state == MAC) begin
         i        <= i + 7'd1;
         w_addr_q <= w_addr_c;
      end else if (state == WRITE) begin
         i <= '0;
         j <= last_j ? j : j + 7'd1;
      end

   always_comb begin
      state_nxt         = state;
      clr               = 1'b0;
      en                = 1'b0;
      busy              = 1'b1;
      done              = 1'b0;
      ram_oe            = 1'b0;
      ram_wre           = 1'b0;
      ram_read_address  = '0;
      ram_write_address = '0;
      ram_write_data    = '0;
      w_addr            = w_addr_q;
      case (state)
         IDLE: begin
            busy      = 1'b0;
            clr       = start;
            state_nxt = start ? MAC : IDLE;
         end
         MAC: begin
            en               = 1'b1;
            ram_oe           = 1'b1;
            ram_read_address = 8'(IN_BASE) + {1'b0, i};
            w_addr           = w_addr_c;
            state_nxt        = last_i ? WRITE : MAC;
         end
         WRITE: begin
            ram_wre           = 1'b1;
            ram_write_address = 8'(OUT_BASE) + {1'b0, j};
            ram_write_data    = result;
            clr               = 1'b1;
            state_nxt         = last_j ? DONE : MAC;
         end
         default: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end
endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// tb_neuron_layer_sequencer: directed self-checking bench for neuron_layer_sequencer (default parameters).
`timescale 1ns/1ps
module tb_neuron_layer_sequencer;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic busy, done, ram_oe, ram_wre;
   logic [7:0] ram_read_address, ram_write_address, w_addr;
   logic [7:0] ram_read_data, ram_write_data, w_data;
   logic [7:0] ram [256];
   logic [7:0] rom [256];
   int cyc = 0, c0 = 0, n_wr = 0, done_cyc = -1;
   int wr_addr [8], wr_data [8], wr_cyc [8];
   int n_cmp = 0, n_bad = 0;

   neuron_layer_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .ram_read_address(ram_read_address), .ram_oe(ram_oe), .ram_read_data(ram_read_data),
      .ram_write_address(ram_write_address), .ram_write_data(ram_write_data), .ram_wre(ram_wre),
      .w_addr(w_addr), .w_data(w_data)
   );

   assign ram_read_data = ram[ram_read_address];
   assign w_data        = rom[w_addr];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ram_wre) begin
         if (n_wr < 8) begin
            wr_addr[n_wr] = int'(ram_write_address);
            wr_data[n_wr] = int'(ram_write_data);
            wr_cyc[n_wr]  = cyc - c0;
         end
         n_wr++;
      end
      if (done) done_cyc = cyc - c0;
   end

   task automatic check(input string tag, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int relu(input int v);
`ifdef NEURON_RELU_EN
      return v[7] ? 0 : v;
`else
      return v;
`endif
   endfunction

   // x holds inputs 0..3 low byte first; w holds weights 0..7 low byte first.
   task automatic load(input logic [31:0] x, input logic [63:0] w);
      for (int k = 0; k < 256; k++) begin
         ram[k] = 8'h00;
         rom[k] = 8'h00;
      end
      for (int k = 0; k < 4; k++) ram[k] = x[8*k +: 8];
      for (int k = 0; k < 8; k++) rom[k] = w[8*k +: 8];
   endtask

   task automatic run_layer(input bit spurious);
      n_wr     = 0;
      done_cyc = -1;
      @(posedge clk); #1;
      start = 1'b1;
      c0    = cyc;
      for (int k = 0; k < 40 && done_cyc < 0; k++) begin
         @(posedge clk); #1;
         start = spurious && (k + 1 == 3 || k + 1 == 7);
      end
      start = 1'b0;
   endtask

   task automatic check_pair(input string tag, input int d0, input int d1);
      check({tag, "_nwr"}, n_wr, 2);
      check({tag, "_addr0"}, wr_addr[0], 20);
      check({tag, "_data0"}, wr_data[0], d0);
      check({tag, "_addr1"}, wr_addr[1], 21);
      check({tag, "_data1"}, wr_data[1], d1);
   endtask

   initial begin
      for (int k = 0; k < 256; k++) begin
         ram[k] = 8'h00;
         rom[k] = 8'h00;
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wre", ram_wre, 0);
      check("rst_oe", ram_oe, 0);
      check("rst_raddr", ram_read_address, 0);
      check("rst_waddr", ram_write_address, 0);
      check("rst_wdata", ram_write_data, 0);
      check("rst_w_addr", w_addr, 0);
      rst = 1'b0;

      // 7+2+3+1 = 13, then -13; spurious starts mid-run must be ignored.
      load(32'h01_03_02_07, 64'hFF_FF_FF_FF_01_01_01_01);
      run_layer(1'b1);
      check_pair("sum", 8'h0D, relu(8'hF3));
      check("sum_wcyc0", wr_cyc[0], 5);
      check("sum_wcyc1", wr_cyc[1], 10);
      check("sum_done_cyc", done_cyc, 11);
      check("sum_idle_busy", busy, 0);
      check("sum_idle_w_addr", w_addr, 7);

      // 4*127*127 saturates high; 4*127*-128 saturates low.
      load(32'h7F_7F_7F_7F, 64'h80_80_80_80_7F_7F_7F_7F);
      run_layer(1'b0);
      check_pair("sat", 8'h7F, relu(8'h80));

      // Just past each limit: 128 -> 127, -129 -> -128.
      load(32'h00_00_01_7F, 64'h00_00_FE_FF_00_00_01_01);
      run_layer(1'b0);
      check_pair("edge", 8'h7F, relu(8'h80));

      // Exactly at the limits: 127 and -128 pass through.
      load(32'h00_00_00_7F, 64'h00_00_FF_FF_00_00_00_01);
      ram[2] = 8'h01;
      rom[6] = 8'hFF;
      run_layer(1'b0);
      check_pair("limit", 8'h7F, relu(8'h80));

      // Abort in MAC cycle 3; nothing may be written, then a clean rerun.
      load(32'h01_03_02_07, 64'hFF_FF_FF_FF_01_01_01_01);
      n_wr = 0;
      @(posedge clk); #1;
      start = 1'b1;
      c0    = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("abort_busy_pre", busy, 1);
      check("abort_oe_pre", ram_oe, 1);
      check("abort_raddr_pre", ram_read_address, 2);
      rst = 1'b1;
      #1;
      check("abort_busy", busy, 0);
      check("abort_oe", ram_oe, 0);
      check("abort_w_addr", w_addr, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check("abort_nwr", n_wr, 0);
      run_layer(1'b0);
      check_pair("rerun", 8'h0D, relu(8'hF3));
      check("rerun_done_cyc", done_cyc, 11);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/neuron_layer_sequencer.md
NEURON_LAYER_SEQUENCER -- requirements
Module: neuron_layer_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Parameter N_IN, default 4: input neurons per output, range 1..64.
REQ-003 Parameter N_OUT, default 2: output neurons computed per run, range 1..64.
REQ-004 Parameter IN_BASE, default 0: RAM address of input neuron 0.
REQ-005 Parameter OUT_BASE, default 20: RAM address of output neuron 0.
REQ-006 Parameter FRAC, default 0: arithmetic right shift applied to the accumulator before saturation, range 0..8.
REQ-007 Ports SHALL be as follows:
- clk  in  1  clock
- rst  in  1  async reset, active high
- start  in  1  single-cycle run request
- busy  out  1  high while a run is in progress
- done  out  1  single-cycle completion pulse
- ram_read_address  out  8  neuron RAM read address
- ram_oe  out  1  neuron RAM output enable
- ram_read_data  in  8  signed neuron value, combinational read
- ram_write_address  out  8  neuron RAM write address
- ram_write_data  out  8  signed result
- ram_wre  out  1  neuron RAM write enable
- w_addr  out  8  weight ROM address
- w_data  in  8  signed weight, combinational read

Function
REQ-008 The FSM SHALL have four states: IDLE, MAC, WRITE and DONE.
REQ-009 IDLE->MAC on start=1; i=0, j=0, acc=0 at that edge.
REQ-010 In MAC, ram_oe=1, ram_read_address=IN_BASE+i, and w_addr=j*N_IN+i; at each edge, acc += ram_read_data*w_data (signed 8x8->16, sign-extended into a 22-bit signed acc) and i increments.
REQ-011 MAC->WRITE after the edge that consumes i=N_IN-1.
REQ-012 In WRITE, ram_oe=0, ram_wre=1 for exactly one cycle, ram_write_address=OUT_BASE+j, and ram_write_data=sat8(acc>>>FRAC).
REQ-013 At the edge leaving WRITE, the FSM SHALL go to MAC with i=0, acc=0, j+1 if j<N_OUT-1, else to DONE.
REQ-014 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-015 busy=1 in MAC, WRITE and DONE.
REQ-016 Latency from the start edge to the done cycle SHALL be N_OUT*(N_IN+1) cycles; done is high during cycle N_OUT*(N_IN+1)+1.
REQ-017 sat8: values >127 SHALL become 127 and values <-128 SHALL become -128; otherwise the result is the low 8 bits.
REQ-018 start while busy=1 SHALL be ignored; it is neither queued nor restarts the run.
REQ-019 Address arithmetic SHALL wrap modulo 256.
REQ-020 The input and output regions SHALL NOT overlap; this is a parameter rule, checked by an elaboration-time assertion.
REQ-021 Outside MAC, ram_oe=0 and w_addr holds its last value; outside WRITE, ram_wre=0.

Reset
REQ-022 rst=1 SHALL asynchronously force IDLE, busy=0, done=0, ram_wre=0, ram_oe=0, all addresses=0, ram_write_data=0, acc=0, i=0 and j=0.
REQ-023 Reset mid-run SHALL abort the run with no further writes; a write in progress in that cycle is dropped.

Configuration
REQ-024 With macro NEURON_RELU_EN defined, negative results SHALL be written as 0 after saturation (ReLU).
REQ-025 Without NEURON_RELU_EN, the signed saturated value SHALL be written unchanged.

Structure
REQ-026 Package neuron_pkg SHALL hold the FSM state enum, NEURON_W=8, ACC_W=22 and the sat8 function.
REQ-027 The multiply-accumulate SHALL be the sub-module neuron_mac, with ports clr, en, a, b and acc.

Verification
REQ-028 Inputs 7,2,3,1 and weights 1,1,1,1 (N_OUT=1, FRAC=0) -> single write of 0x0D at address 20.
REQ-029 Inputs all 127 and weights all 127 -> 0x7F written; inputs all 127 and weights all -128 -> 0x80 written (0x00 with NEURON_RELU_EN).
REQ-030 Inputs 7,2,3,1 and weights all -1 -> 0xF3 written without the macro, 0x00 with it.
REQ-031 N_IN=4, N_OUT=2, start at cycle 0 -> writes in cycles 5 and 10 to addresses 20 and 21; done high in cycle 11; start pulses in cycles 3 and 7 have no effect.
REQ-032 rst asserted in cycle 3 of MAC -> ram_wre is never asserted, busy=0 immediately; the next start gives correct results.
